// File: rtl/dmadd_vec.sv
// dmadd_vec: multi-lane multiply-accumulate engine.
// Operands are loaded into an A/B register file, a run command walks the lanes
// one per cycle into a wide accumulator, and the accumulator is read a byte at
// a time on the 8-bit output bus.
// Optional feature macro: DMADD_VEC_SATURATE_EN (saturating accumulate instead
// of modulo-2^ACC_W wrap).
module dmadd_vec #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 4,
    parameter int unsigned ACC_W = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             run,
    input  logic             load,
    input  logic [1:0]       insn,
    input  logic [IDX_W-1:0] index,
    input  logic [DW-1:0]    data,
    output logic [7:0]       out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned NBYTES = ACC_W / 8;
    localparam int unsigned OSEL_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned PW     = 2 * DW;

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    state_e              state_q;
    logic [LANE_W-1:0]   lane_q;
    logic                mode_q;   // 1: signed MAC
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_next;
    logic [OSEL_W-1:0]   osel_q;
    logic                busy_q;
    logic                done_q;
    logic [DW-1:0]       a_q [LANES];
    logic [DW-1:0]       b_q [LANES];

    logic                wr_hit;
    logic                wr_en;
    logic [LANE_W-1:0]   wr_lane;
    logic                wr_is_b;

    // Indices 0..LANES-1 hit A, LANES..2*LANES-1 hit B; anything above is dropped.
    assign wr_hit  = 32'(index) < 32'(2 * LANES);
    assign wr_en   = ena && load && (state_q == StIdle) && wr_hit;
    assign wr_lane = index[LANE_W-1:0];
    assign wr_is_b = index[LANE_W];

    // Operand register file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LANES); i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else if (wr_en) begin
            if (wr_is_b) begin
                b_q[wr_lane] <= data;
            end else begin
                a_q[wr_lane] <= data;
            end
        end
    end

    logic [DW-1:0]        a_cur;
    logic [DW-1:0]        b_cur;
    logic signed [DW-1:0] a_s;
    logic signed [DW-1:0] b_s;
    logic [PW-1:0]        prod_u;
    logic signed [PW-1:0] prod_s;
    logic [ACC_W-1:0]     prod_ext;

    // Current-lane product, zero- or sign-extended according to the latched mode.
    always_comb begin
        a_cur    = a_q[lane_q];
        b_cur    = b_q[lane_q];
        a_s      = a_cur;
        b_s      = b_cur;
        prod_u   = PW'(a_cur) * PW'(b_cur);
        prod_s   = PW'(a_s) * PW'(b_s);
        prod_ext = mode_q ? {{(ACC_W - PW){prod_s[PW-1]}}, prod_s}
                          : {{(ACC_W - PW){1'b0}}, prod_u};
    end

`ifdef DMADD_VEC_SATURATE_EN
    logic [ACC_W:0] sum_w;
    assign sum_w = {1'b0, acc_q} + {1'b0, prod_ext};

    // Saturating accumulate: unsigned clamps on carry out, signed on overflow.
    always_comb begin
        acc_next = sum_w[ACC_W-1:0];
        if (mode_q) begin
            if ((acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                (sum_w[ACC_W-1] != acc_q[ACC_W-1])) begin
                acc_next = acc_q[ACC_W-1] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                          : {1'b0, {(ACC_W - 1){1'b1}}};
            end
        end else if (sum_w[ACC_W]) begin
            acc_next = '1;
        end
    end
`else
    // Plain modulo-2^ACC_W accumulate.
    always_comb begin
        acc_next = acc_q + prod_ext;
    end
`endif

    // Command FSM with accumulator, byte select and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            lane_q  <= '0;
            mode_q  <= 1'b0;
            acc_q   <= '0;
            osel_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (ena) begin
            unique case (state_q)
                StIdle: begin
                    // A load in the same cycle wins; run must be re-presented.
                    if (run && !load) begin
                        unique case (insn)
                            2'b00, 2'b11: begin
                                state_q <= StMac;
                                lane_q  <= '0;
                                mode_q  <= insn[1];
                                busy_q  <= 1'b1;
                            end
                            2'b01: begin
                                acc_q   <= '0;
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end
                            2'b10: begin
                                osel_q  <= OSEL_W'(32'(index) % NBYTES);
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                StMac: begin
                    acc_q <= acc_next;
                    if (lane_q == LANE_W'(LANES - 1)) begin
                        lane_q  <= '0;
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        lane_q <= lane_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output byte mux from the registered accumulator and byte select.
    always_comb begin
        out = '0;
        for (int i = 0; i < int'(NBYTES); i++) begin
            if (OSEL_W'(i) == osel_q) begin
                out = acc_q[8*i +: 8];
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_dmadd_vec.sv
// Scoreboard bench for dmadd_vec (LANES=4, DW=4, ACC_W=16). Expected results
// come from an integer reference model; a monitor checks each done pulse.
module tb_dmadd_vec;

    localparam int LANES = 4;
    localparam int DW    = 4;
    localparam int ACC_W = 16;
    localparam int IDX_W = 4;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic             run;
    logic             load;
    logic [1:0]       insn;
    logic [IDX_W-1:0] index;
    logic [DW-1:0]    data;
    logic [7:0]       out;
    logic             busy;
    logic             done;

    dmadd_vec #(
        .LANES(LANES),
        .DW   (DW),
        .ACC_W(ACC_W),
        .IDX_W(IDX_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .run  (run),
        .load (load),
        .insn (insn),
        .index(index),
        .data (data),
        .out  (out),
        .busy (busy),
        .done (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int out_v;
        int busy_n;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   issued;
    int   completed;
    int   aborted;
    int   busy_cnt;

    // Reference model state
    int m_a[LANES];
    int m_b[LANES];
    int m_acc;
    int m_osel;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < LANES; i++) begin
            m_a[i] = 0;
            m_b[i] = 0;
        end
        m_acc  = 0;
        m_osel = 0;
    endfunction

    function automatic int sx(input int v);
        return (v >= (1 << (DW - 1))) ? v - (1 << DW) : v;
    endfunction

    function automatic void model_add(input int p, input bit sgn);
`ifdef DMADD_VEC_SATURATE_EN
        int s;
        if (sgn) begin
            s = ((m_acc >= 32768) ? m_acc - 65536 : m_acc) + p;
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
        end else begin
            s = m_acc + p;
            if (s > 65535) s = 65535;
        end
        m_acc = s & 32'hFFFF;
`else
        m_acc = (m_acc + p) & 32'hFFFF;
`endif
    endfunction

    function automatic void model_cmd(input int ins, input int idx);
        case (ins)
            0, 3: begin
                for (int l = 0; l < LANES; l++) begin
                    if (ins == 3) model_add(sx(m_a[l]) * sx(m_b[l]), 1'b1);
                    else model_add(m_a[l] * m_b[l], 1'b0);
                end
            end
            1: m_acc = 0;
            default: m_osel = idx % (ACC_W / 8);
        endcase
    endfunction

    function automatic int model_out();
        return (m_acc >> (8 * m_osel)) & 255;
    endfunction

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out", int'(out), e.out_v);
                    chk("busy_cycles", busy_cnt, e.busy_n);
                end
                busy_cnt = 0;
                completed++;
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while ((completed + aborted < issued) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (completed + aborted < issued) begin
            chk("done_timeout", 0, 1);
            aborted = issued - completed;
        end
        #1;
    endtask

    task automatic load_reg(input int idx, input int v);
        load  = 1'b1;
        index = IDX_W'(idx);
        data  = DW'(v);
        @(posedge clk);
        #1;
        load = 1'b0;
        if (idx < LANES) m_a[idx] = v;
        else if (idx < 2 * LANES) m_b[idx - LANES] = v;
    endtask

    // hold > 0 drops ena for that many cycles while lane 2 is pending.
    task automatic run_cmd(input int ins, input int idx, input int hold);
        exp_t e;
        model_cmd(ins, idx);
        e.out_v  = model_out();
        e.busy_n = (ins == 0 || ins == 3) ? LANES + hold : 0;
        sb.push_back(e);
        issued++;
        run   = 1'b1;
        insn  = 2'(ins);
        index = IDX_W'(idx);
        @(posedge clk);
        #1;
        run = 1'b0;
        if (hold > 0) begin
            repeat (2) @(posedge clk);
            #1;
            ena = 1'b0;
            repeat (hold) @(posedge clk);
            #1;
            ena = 1'b1;
        end
        wait_done();
    endtask

    initial begin
        checks = 0; errors = 0; issued = 0; completed = 0; aborted = 0; busy_cnt = 0;
        rst_n = 1'b0; ena = 1'b1; run = 1'b0; load = 1'b0;
        insn = '0; index = '0; data = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", int'(out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_cmd(0, 0, 0);

        // Unsigned dot product, twice
        for (int i = 0; i < LANES; i++) begin
            load_reg(i, i + 1);
            load_reg(LANES + i, i + 5);
        end
        run_cmd(0, 0, 0);
        chk("dot_70", int'(out), 8'h46);
        run_cmd(0, 0, 0);
        chk("dot_140", int'(out), 8'h8C);

        // Signed: -1 * 7 over four lanes
        run_cmd(1, 0, 0);
        for (int i = 0; i < LANES; i++) begin
            load_reg(i, 15);
            load_reg(LANES + i, 7);
        end
        run_cmd(3, 0, 0);
        chk("signed_lo", int'(out), 8'hE4);
        run_cmd(2, 1, 0);
        chk("signed_hi", int'(out), 8'hFF);
        run_cmd(2, 0, 0);

        // Overflow: 73 runs of 900
        for (int i = 0; i < 2 * LANES; i++) load_reg(i, 15);
        run_cmd(1, 0, 0);
        for (int r = 0; r < 73; r++) run_cmd(0, 0, 0);
`ifdef DMADD_VEC_SATURATE_EN
        chk("ovf_lo", int'(out), 8'hFF);
`else
        chk("ovf_lo", int'(out), 8'hA4);
`endif
        run_cmd(2, 1, 0);
        run_cmd(2, 0, 0);

        // Load and run together: only the load takes effect
        for (int i = 0; i < LANES; i++) begin
            load_reg(i, i + 1);
            load_reg(LANES + i, i + 5);
        end
        run_cmd(1, 0, 0);
        load = 1'b1; run = 1'b1; insn = 2'b00; index = 4'd2; data = 4'd9;
        @(posedge clk);
        #1;
        load = 1'b0; run = 1'b0;
        m_a[2] = 9;
        @(negedge clk);
        chk("ldrun_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        run_cmd(0, 0, 0);
        load_reg(2, 3);

        // ena dropped for three cycles at lane 2
        run_cmd(1, 0, 0);
        run_cmd(0, 0, 3);
        chk("ena_hold", int'(out), 8'h46);

        // Reset asserted at lane 2: partial sum and registers discarded
        begin
            exp_t e;
            e.out_v = 0; e.busy_n = 0;
            sb.push_back(e);
            issued++;
        end
        run = 1'b1; insn = 2'b00;
        @(posedge clk);
        #1;
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        aborted = issued - completed;
        model_reset();
        @(negedge clk);
        chk("abort_out", int'(out), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cmd(0, 0, 0);
        run_cmd(2, 1, 0);
        run_cmd(2, 0, 0);

        // Randomized mix of loads and commands
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 9) < 5) begin
                load_reg(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end else begin
                run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 0);
            end
        end

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmadd_vec.md
# dmadd_vec

Parametrised multi-lane multiply-accumulate engine; the next generation of the single-lane DMADD core behind the TinyTapeout top. Operand pairs are loaded nibble-wise into a small register file. A run command computes a dot product serially, one lane per cycle, into a wide accumulator. The accumulator is then read out one byte at a time on the 8-bit output bus.

## Interface
- `LANES`, default 4: operand pairs (A_i, B_i); power of two, 2..8.
- `DW`, default 4: operand width in bits.
- `ACC_W`, default 16: accumulator width; multiple of 8, at least 2*DW + log2(LANES).
- `IDX_W`, default 4: index width; 2^IDX_W ≥ 2*LANES.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: clock enable; low freezes all state, including FSM, accumulator and registers.
- `run` in 1: start the command on `insn`; level-sampled in IDLE.
- `load` in 1: write `data` to the operand register at `index`.
- `insn` in 2: 00 = unsigned MAC, 01 = clear accumulator, 10 = select output byte, 11 = signed MAC.
- `index` in IDX_W: register address for load; byte select for insn 10.
- `data` in DW: operand write data.
- `out` out 8: selected accumulator byte.
- `busy` out 1: high while MAC lanes are being processed.
- `done` out 1: one-cycle pulse when a command completes.

## Operation
- Register file:
  - Index 0..LANES-1 addresses A_0..A_{LANES-1}; LANES..2*LANES-1 addresses B_0..B_{LANES-1}.
  - A load to an out-of-range index is ignored.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - `load` writes the register file.
  - `run` with insn 00 or 11 goes to MAC with lane counter = 0.
  - `run` with insn 01 clears acc to 0 and goes to DONE.
  - `run` with insn 10 sets osel = index mod (ACC_W/8) and goes to DONE.
- Load and run together in IDLE: load executes, run is ignored that cycle. The host must re-present run.
- MAC:
  - Each cycle, acc ← acc + A_lane*B_lane and the lane counter increments.
  - After lane LANES-1, go to DONE.
  - `load` and `run` are ignored in MAC.
- DONE: `done` = 1 for this one cycle, then IDLE unconditionally.
- Arithmetic:
  - Product is 2*DW bits.
  - insn 00: operands zero-extended, product zero-extended to ACC_W.
  - insn 11: operands two's complement, product sign-extended to ACC_W.
  - The MAC mode is latched at start and is constant for the whole operation.
- Overflow: wraps modulo 2^ACC_W by default; see Configuration.
- `out` = acc[8*osel +: 8]. It is combinational from registered acc and osel.
- Reset values: all A/B registers 0, acc 0, osel 0, state IDLE, lane counter 0, `out` = 0, `busy` = 0, `done` = 0.

## Timing
- Run sampled in IDLE at edge t (MAC):
  - `busy` = 1 during cycles t+1..t+LANES.
  - acc holds its final value after edge t+LANES.
  - `done` = 1 in cycle t+LANES+1.
  - Latency is LANES+1 cycles.
- Clear and select: `done` in cycle t+1; acc or osel updated after edge t.
- Back-to-back: the earliest next run is sampled the cycle after DONE, so MAC throughput is one per LANES+2 cycles.
- `ena` low mid-MAC: FSM and lane counter hold. Processing resumes on the same lane when `ena` returns, so the result equals the uninterrupted one. If `ena` drops in DONE, `done` stays high until `ena` returns.
- `rst_n` low at any time, including mid-MAC, forces all reset values immediately (asynchronously). The partial sum is discarded.

## Configuration
- `DMADD_VEC_SATURATE_EN` defined:
  - insn 00 clamps to 2^ACC_W-1 on overflow.
  - insn 11 clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - The clamp is applied per lane step; a clamped acc stays clamped until the next add moves it back in range.
- Not defined: plain modulo-2^ACC_W wrap; no saturation logic is synthesised.

## Test plan
All scenarios use LANES=4, DW=4, ACC_W=16.
- Reset: rst_n low then high → out=0x00, busy=0, done=0; an immediate MAC with no loads gives acc=0.
- Load A=1,2,3,4 and B=5,6,7,8, then run insn 00 → busy high for 4 cycles, done in the 5th cycle, out=0x46 (70); a second run gives out=0x8C (140).
- Clear, load all A=0xF and all B=0x7, run insn 11 → acc=0xFFE4 (-28): out=0xE4, then after run insn 10 with index=1, out=0xFF.
- Load all A=B=0xF, clear, then 73 unsigned MAC runs (900 each) → with DMADD_VEC_SATURATE_EN, out bytes read 0xFF,0xFF; without it, acc=0x00A4.
- Assert load and run together in IDLE → register written, busy stays 0, no done; the next run alone starts the MAC.
- Drop ena for 3 cycles at MAC lane 2, then restore → result still 0x46 with done delayed 3 cycles; separately, pull rst_n low at lane 2 → acc=0, busy=0, all registers 0.
